alu_cmd_issuer: RTL

//  Upstream stage of the FIFO/ALU pipeline: accepts operand pairs + opcode from the host side,

---
 rtl/alu_cmd_issuer_if.sv | 32 +++
 rtl/alu_cmd_issuer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer_if.sv
// Host-side and pipeline-side signal bundle for the ALU command issuer.
//
// Handshake rules, shared by both channels:
//   - A producer raises *_valid only from its own registered state and keeps the
//     payload stable until the cycle in which *_valid && *_ready is seen on a
//     rising clock edge. A valid is never retracted before that transfer.
//   - A consumer may drive *_ready independently of *_valid.
//   - A transfer happens on every rising edge where both valid and ready are high.
//   - rsp_valid has no ready: each cycle it is high returns one credit.
interface alu_cmd_issuer_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [1:0] in_op;
  logic [9:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       rsp_valid;

  // Host / pipeline side (drives commands in, takes command words out)
  modport master (
    output in_valid, in_a, in_b, in_op, cmd_ready, rsp_valid,
    input  in_ready, cmd_data, cmd_valid
  );

  // Issuer side
  modport slave (
    input  in_valid, in_a, in_b, in_op, cmd_ready, rsp_valid,
    output in_ready, cmd_data, cmd_valid
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Upstream stage of the FIFO/ALU pipeline. Accepts {a, b, op} from the host,
// drops divide-by-zero commands, buffers up to two commands in order and issues
// them as 10-bit words {op, b, a} under credit-based flow control: at most
// MAX_OUTSTANDING commands may be issued and not yet retired.
//
// FSM encoding (visible on state_dbg): 0 IDLE, 1 ISSUE, 2 BLOCKED.
// The state register always reflects the registered buffer occupancy and
// credit count: IDLE = buffer empty, BLOCKED = entries waiting but no credit,
// ISSUE = an entry is ready to go and a credit is available.
module alu_cmd_issuer #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int DROP_DIV0       = 1,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_cmd_issuer_if.slave      bus,
  output logic [3:0]           outstanding,
  output logic                 err_div0,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic                 rsp_err,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_BLOCKED = 2'd2
  } state_t;

  localparam logic [3:0]           MAX_OUT = 4'(MAX_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Registered state
  state_t                 state_q,    state_d;
  logic [9:0]             buf_q [2];
  logic [9:0]             buf_d [2];
  logic                   wr_ptr_q,   wr_ptr_d;
  logic                   rd_ptr_q,   rd_ptr_d;
  logic [1:0]             occ_q,      occ_d;
  logic [3:0]             out_q,      out_d;
  logic                   rdy_en_q,   rdy_en_d;
  logic                   err_div0_q, err_div0_d;
  logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
  logic                   rsp_err_q,  rsp_err_d;

  // Per-cycle events
  logic       in_ready_w;
  logic       cmd_valid_w;
  logic [9:0] head_w;
  logic       accept;
  logic       is_div0;
  logic       drop;
  logic       store;
  logic       xfer;
  logic       credit_ret;
  logic       stray_rsp;

  // Handshake outputs and per-cycle events, derived from registered state only
  always_comb begin
    in_ready_w  = rdy_en_q && (occ_q != 2'd2);
    head_w      = buf_q[rd_ptr_q];
    cmd_valid_w = (occ_q != 2'd0) && (out_q < MAX_OUT) && (state_q == ST_ISSUE);
    accept      = bus.in_valid && in_ready_w;
    is_div0     = (bus.in_op == 2'd3) && (bus.in_b == 4'd0);
    drop        = accept && (DROP_DIV0 != 0) && is_div0;
    store       = accept && !drop;
    xfer        = cmd_valid_w && bus.cmd_ready;
    credit_ret  = bus.rsp_valid && (out_q != 4'd0);
    stray_rsp   = bus.rsp_valid && (out_q == 4'd0);
  end

  // Skid buffer: in-order two-entry FIFO with independent read/write pointers
  always_comb begin
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (store) begin
      buf_d[wr_ptr_q] = {bus.in_op, bus.in_b, bus.in_a};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (xfer) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({store, xfer})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Credit counter, divide-by-zero flagging and stray-response detection
  always_comb begin
    out_d      = out_q;
    err_div0_d = drop;
    drop_cnt_d = drop_cnt_q;
    rsp_err_d  = rsp_err_q || stray_rsp;
    rdy_en_d   = 1'b1;
    case ({xfer, credit_ret})
      2'b10:   out_d = out_q + 4'd1;
      2'b01:   out_d = out_q - 4'd1;
      default: out_d = out_q;
    endcase
    if (drop && (drop_cnt_q != {CNT_WIDTH{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNT_ONE;
    end
  end

  // Next-state logic: follows the next buffer occupancy and credit count
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (occ_d != 2'd0) begin
          state_d = (out_d >= MAX_OUT) ? ST_BLOCKED : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (occ_d == 2'd0) begin
          state_d = ST_IDLE;
        end else if (out_d >= MAX_OUT) begin
          state_d = ST_BLOCKED;
        end
      end
      ST_BLOCKED: begin
        if (occ_d == 2'd0) begin
          state_d = ST_IDLE;
        end else if (out_d < MAX_OUT) begin
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous active-low reset; reset discards everything
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      out_q      <= 4'd0;
      rdy_en_q   <= 1'b0;
      err_div0_q <= 1'b0;
      drop_cnt_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      out_q      <= out_d;
      rdy_en_q   <= rdy_en_d;
      err_div0_q <= err_div0_d;
      drop_cnt_q <= drop_cnt_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Output wiring; cmd_data reads zero whenever no command is offered
  always_comb begin
    bus.in_ready  = in_ready_w;
    bus.cmd_valid = cmd_valid_w;
    bus.cmd_data  = cmd_valid_w ? head_w : 10'd0;
    outstanding   = out_q;
    err_div0      = err_div0_q;
    drop_cnt      = drop_cnt_q;
    rsp_err       = rsp_err_q;
    state_dbg     = state_q;
  end

endmodule
